// File: rtl/usr_pkg.sv
// -----------------------------------------------------------------------------
// usr_pkg
// Shared definitions for the universal shift register.
//   - Mode-select encodings driven on the S input of usr_shift_reg.
//   - count_width(): width needed to hold a fill count from 0 to WIDTH.
// No ports: this is a package.
// -----------------------------------------------------------------------------
package usr_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   // The count must reach WIDTH itself, hence WIDTH+1 distinct values.
   function automatic int count_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/usr_fill_cnt.sv
// -----------------------------------------------------------------------------
// usr_fill_cnt
// Saturating fill counter. It counts serial bits shifted into the register
// and stops at WIDTH. The full flag is registered alongside the count and
// rises on the same edge that the count reaches WIDTH.
// Ports:
//   clk   in  1   clock, rising edge
//   srst  in  1   synchronous active-high reset (clears count and flag)
//   clr   in  1   clear count and flag (parallel load)
//   inc   in  1   one serial bit entered this cycle
//   cnt   out CW  current fill count, 0..WIDTH
//   full  out 1   high when cnt == WIDTH
// -----------------------------------------------------------------------------
module usr_fill_cnt #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic          clk,
   input  logic          srst,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] cnt,
   output logic          full
);

   localparam logic [CW-1:0] LIMIT = CW'(WIDTH);

   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;
   logic          full_reg;
   logic          full_next;

   always_comb begin
      cnt_next  = cnt_reg;
      full_next = full_reg;
      if (clr) begin
         cnt_next  = '0;
         full_next = 1'b0;
      end else if (inc && !full_reg) begin
         // The full flag doubles as the saturation guard, so the adder never
         // has to compare against the limit before incrementing.
         cnt_next  = cnt_reg + 1'b1;
         full_next = (cnt_next == LIMIT);
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         cnt_reg  <= '0;
         full_reg <= 1'b0;
      end else begin
         cnt_reg  <= cnt_next;
         full_reg <= full_next;
      end
   end

   assign cnt  = cnt_reg;
   assign full = full_reg;

endmodule

// File: rtl/usr_shift_reg.sv
// -----------------------------------------------------------------------------
// usr_shift_reg
// Universal WIDTH-bit shift register: hold, shift right, shift left and
// parallel load, with a registered serial-out bit and a saturating fill
// counter. All outputs are registered.
// Optional feature: define USR_ROTATE_EN to add the Rot input. With Rot=1 in
// a shift mode the fill bit comes from the opposite end of the register
// (rotate) instead of DSR/DSL.
// Ports:
//   Cp    in  1      clock, rising edge
//   Rst   in  1      synchronous active-high reset, overrides S
//   S     in  2      mode: 00 hold, 01 shift right, 10 shift left, 11 load
//   DSR   in  1      serial input for shift right (enters Q[WIDTH-1])
//   DSL   in  1      serial input for shift left (enters Q[0])
//   D     in  WIDTH  parallel load data
//   Rot   in  1      rotate select (only with USR_ROTATE_EN)
//   Q     out WIDTH  register contents
//   SO    out 1      last bit shifted out
//   Cnt   out CW     bits shifted in since last load/reset, saturates at WIDTH
//   Full  out 1      high when Cnt == WIDTH
// -----------------------------------------------------------------------------
module usr_shift_reg
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CW    = count_width(WIDTH)
) (
   input  logic             Cp,
   input  logic             Rst,
   input  logic [1:0]       S,
   input  logic             DSR,
   input  logic             DSL,
   input  logic [WIDTH-1:0] D,
`ifdef USR_ROTATE_EN
   input  logic             Rot,
`endif
   output logic [WIDTH-1:0] Q,
   output logic             SO,
   output logic [CW-1:0]    Cnt,
   output logic             Full
);

   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] q_next;
   logic             so_reg;
   logic             so_next;
   logic             rot_sel;
   logic             fill_r;
   logic             fill_l;
   logic             shift_en;
   logic             load_en;

`ifdef USR_ROTATE_EN
   assign rot_sel = Rot;
`else
   assign rot_sel = 1'b0;
`endif

   // Bit entering the register for each direction; rotation wraps the
   // outgoing end bit back around.
   assign fill_r = rot_sel ? q_reg[0]       : DSR;
   assign fill_l = rot_sel ? q_reg[WIDTH-1] : DSL;

   always_comb begin
      q_next   = q_reg;
      so_next  = so_reg;
      shift_en = 1'b0;
      load_en  = 1'b0;
      case (S)
         MODE_SHR: begin
            q_next   = {fill_r, q_reg[WIDTH-1:1]};
            so_next  = q_reg[0];
            shift_en = 1'b1;
         end
         MODE_SHL: begin
            q_next   = {q_reg[WIDTH-2:0], fill_l};
            so_next  = q_reg[WIDTH-1];
            shift_en = 1'b1;
         end
         MODE_LOAD: begin
            q_next  = D;
            load_en = 1'b1;
         end
         default: begin
            q_next  = q_reg;
            so_next = so_reg;
         end
      endcase
   end

   always_ff @(posedge Cp) begin
      if (Rst) begin
         q_reg  <= '0;
         so_reg <= 1'b0;
      end else begin
         q_reg  <= q_next;
         so_reg <= so_next;
      end
   end

   usr_fill_cnt #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_fill_cnt (
      .clk  (Cp),
      .srst (Rst),
      .clr  (load_en),
      .inc  (shift_en),
      .cnt  (Cnt),
      .full (Full)
   );

   assign Q  = q_reg;
   assign SO = so_reg;

endmodule

// File: tb/tb_usr_shift_reg.sv
module tb_usr_shift_reg;

   localparam int W  = 8;
   localparam int CW = $clog2(W + 1);
`ifdef USR_ROTATE_EN
   localparam bit ROT_EN = 1'b1;
`else
   localparam bit ROT_EN = 1'b0;
`endif

   logic          Cp = 1'b0;
   logic          Rst = 1'b1;
   logic [1:0]    S = 2'b00;
   logic          DSR = 1'b0;
   logic          DSL = 1'b0;
   logic [W-1:0]  D = '0;
   logic          Rot = 1'b0;
   logic [W-1:0]  Q;
   logic          SO;
   logic [CW-1:0] Cnt;
   logic          Full;

   int checks = 0;
   int errors = 0;

   // Reference model state: plain integers and vectors.
   logic [W-1:0] m_q;
   logic         m_so;
   int           m_cnt;

   always #5 Cp = ~Cp;

   usr_shift_reg #(.WIDTH(W)) dut (
      .Cp   (Cp),
      .Rst  (Rst),
      .S    (S),
      .DSR  (DSR),
      .DSL  (DSL),
      .D    (D),
`ifdef USR_ROTATE_EN
      .Rot  (Rot),
`endif
      .Q    (Q),
      .SO   (SO),
      .Cnt  (Cnt),
      .Full (Full)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".Q"},    32'(Q),    32'(m_q));
      check({tag, ".SO"},   32'(SO),   32'(m_so));
      check({tag, ".Cnt"},  32'(Cnt),  32'(m_cnt));
      check({tag, ".Full"}, 32'(Full), 32'(m_cnt == W));
   endtask

   // Apply one cycle of inputs, advance the model from the behavioural rules,
   // then compare all outputs.
   task automatic step(input logic rst, input logic [1:0] s, input logic dsr,
                       input logic dsl, input logic [W-1:0] d, input logic rot,
                       input string tag);
      logic fill;
      @(negedge Cp);
      Rst = rst; S = s; DSR = dsr; DSL = dsl; D = d; Rot = rot;
      @(posedge Cp);
      #1;
      if (rst) begin
         m_q = '0; m_so = 1'b0; m_cnt = 0;
      end else if (s == 2'd1) begin
         fill  = (ROT_EN && rot) ? m_q[0] : dsr;
         m_so  = m_q[0];
         m_q   = (m_q >> 1) | (W'(fill) << (W - 1));
         m_cnt = (m_cnt < W) ? m_cnt + 1 : W;
      end else if (s == 2'd2) begin
         fill  = (ROT_EN && rot) ? m_q[W-1] : dsl;
         m_so  = m_q[W-1];
         m_q   = (m_q << 1) | W'(fill);
         m_cnt = (m_cnt < W) ? m_cnt + 1 : W;
      end else if (s == 2'd3) begin
         m_q   = d;
         m_cnt = 0;
      end
      check_model(tag);
   endtask

   initial begin
      m_q = '0; m_so = 1'b0; m_cnt = 0;

      // Reset overrides a load.
      step(1'b1, 2'b11, 1'b0, 1'b0, 8'hA5, 1'b0, "reset");
      check("reset_q", 32'(Q), 32'h0);
      $display("reset: Q=%h SO=%b Cnt=%0d Full=%b", Q, SO, Cnt, Full);

      // Load then hold for three edges.
      step(1'b0, 2'b11, 1'b0, 1'b0, 8'h96, 1'b0, "load96");
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 2'b00, 1'b1, 1'b1, 8'hFF, 1'b0, "hold");
         check("hold_q", 32'(Q), 32'h96);
      end
      $display("load/hold: Q=%h Cnt=%0d", Q, Cnt);

      // Shift right with DSR=1.
      step(1'b0, 2'b01, 1'b1, 1'b0, 8'h00, 1'b0, "shr1");
      check("shr_q", 32'(Q), 32'hCB);
      check("shr_cnt", 32'(Cnt), 32'd1);
      $display("shr: Q=%h SO=%b Cnt=%0d", Q, SO, Cnt);

      // Shift left with DSL=0 from 96.
      step(1'b0, 2'b11, 1'b0, 1'b0, 8'h96, 1'b0, "load96b");
      step(1'b0, 2'b10, 1'b1, 1'b0, 8'h00, 1'b0, "shl1");
      check("shl_q", 32'(Q), 32'h2C);
      check("shl_so", 32'(SO), 32'd1);
      $display("shl: Q=%h SO=%b Cnt=%0d", Q, SO, Cnt);

      // Fill to saturation from reset.
      step(1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, "reset2");
      for (int i = 1; i <= 9; i++) begin
         step(1'b0, 2'b01, 1'b1, 1'b0, 8'h00, 1'b0, "fill");
         if (i == 7) check("fill7_full", 32'(Full), 32'd0);
         if (i >= 8) begin
            check("fill_cnt_sat", 32'(Cnt), 32'd8);
            check("fill_full", 32'(Full), 32'd1);
         end
      end
      check("fill_q", 32'(Q), 32'hFF);
      $display("saturate: Q=%h Cnt=%0d Full=%b", Q, Cnt, Full);
      step(1'b0, 2'b11, 1'b0, 1'b0, 8'h3C, 1'b0, "reload");
      check("reload_full", 32'(Full), 32'd0);
      $display("reload: Q=%h Cnt=%0d Full=%b", Q, Cnt, Full);

      // Rotate-select behaviour (acts as plain shift without the feature).
      step(1'b0, 2'b11, 1'b0, 1'b0, 8'h81, 1'b0, "load81");
      step(1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 1'b1, "rotr");
      check("rot_q", 32'(Q), ROT_EN ? 32'hC0 : 32'h40);
      check("rot_so", 32'(SO), 32'd1);
      $display("rotate-right: Q=%h SO=%b", Q, SO);
      step(1'b0, 2'b11, 1'b0, 1'b0, 8'h81, 1'b0, "load81b");
      step(1'b0, 2'b10, 1'b0, 1'b0, 8'h00, 1'b1, "rotl");
      check("rotl_q", 32'(Q), ROT_EN ? 32'h03 : 32'h02);
      $display("rotate-left: Q=%h SO=%b", Q, SO);

      // Randomised traffic, occasional mid-sequence reset.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 29) == 0), 2'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), W'($urandom), 1'($urandom), "rand");
         $display("rand %0d: Rst=%b S=%b Q=%h SO=%b Cnt=%0d Full=%b",
                  i, Rst, S, Q, SO, Cnt, Full);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
